// File: rtl/pipe_stage_chain_pkg.sv
// Shared MIPS control encodings and the per-stage control bundle
// carried down the pipeline.
package pipe_stage_chain_pkg;

    localparam logic [2:0] PC_NEXT      = 3'd0;
    localparam logic [1:0] WB_ADDR_RD   = 2'd0;
    localparam logic [1:0] WB_ADDR_RT   = 2'd1;
    localparam logic [1:0] WB_ADDR_LINK = 2'd2;
    localparam logic [4:0] LinkReg      = 5'd31;

    typedef struct packed {
        logic [4:0] regw_addr;
        logic       is_branch;
        logic       wb_wen;
        logic       wb_data_src;
        logic       mem_ren;
        logic       mem_wen;
    } ctl_t;

    localparam int unsigned CtlWidth = $bits(ctl_t);

    // An invalid slot must never carry live control, so every field is masked.
    function automatic ctl_t ctl_gate(ctl_t c, logic v);
        ctl_t r;
        r.regw_addr   = c.regw_addr & {5{v}};
        r.is_branch   = c.is_branch & v;
        r.wb_wen      = c.wb_wen & v;
        r.wb_data_src = c.wb_data_src & v;
        r.mem_ren     = c.mem_ren & v;
        r.mem_wen     = c.mem_wen & v;
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Controller/decoder-facing signal bundle of the pipeline stage chain.
interface pipe_stage_chain_if;

    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic [31:0] inst;
    logic [2:0]  pc_src;
    logic [1:0]  wb_addr_src;
    logic        wb_data_src, wb_wen, mem_ren, mem_wen, unrecognized;

    logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic        is_branch_exe, wb_wen_exe, wb_data_src_exe;
    logic [4:0]  regw_addr_exe;
    logic        is_branch_mem, wb_wen_mem, wb_data_src_mem;
    logic [4:0]  regw_addr_mem;
    logic        mem_ren_mem, mem_wen_mem;
    logic [4:0]  regw_addr_wb;
    logic        wb_wen_wb, wb_data_src_wb;
    logic [31:0] retired;
    logic        illegal_seen;

    modport master (
        output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        output if_en, id_en, exe_en, mem_en, wb_en,
        output inst, pc_src, wb_addr_src, wb_data_src, wb_wen, mem_ren, mem_wen, unrecognized,
        input  if_valid, id_valid, exe_valid, mem_valid, wb_valid,
        input  is_branch_exe, wb_wen_exe, wb_data_src_exe, regw_addr_exe,
        input  is_branch_mem, wb_wen_mem, wb_data_src_mem, regw_addr_mem,
        input  mem_ren_mem, mem_wen_mem,
        input  regw_addr_wb, wb_wen_wb, wb_data_src_wb,
        input  retired, illegal_seen
    );

    modport slave (
        input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        input  if_en, id_en, exe_en, mem_en, wb_en,
        input  inst, pc_src, wb_addr_src, wb_data_src, wb_wen, mem_ren, mem_wen, unrecognized,
        output if_valid, id_valid, exe_valid, mem_valid, wb_valid,
        output is_branch_exe, wb_wen_exe, wb_data_src_exe, regw_addr_exe,
        output is_branch_mem, wb_wen_mem, wb_data_src_mem, regw_addr_mem,
        output mem_ren_mem, mem_wen_mem,
        output regw_addr_wb, wb_wen_wb, wb_data_src_wb,
        output retired, illegal_seen
    );

endinterface

// File: rtl/stage_reg.sv
// One pipeline stage register: valid bit plus payload, with
// clear-over-load-over-hold priority.
module stage_reg #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Five-stage valid/control shift chain: carries decoded write-back and memory
// control from ID down to WB, counts retirements and flags illegal issue.
module pipe_stage_chain #(
    parameter logic [2:0] PC_NEXT      = pipe_stage_chain_pkg::PC_NEXT,
    parameter logic [1:0] WB_ADDR_RD   = pipe_stage_chain_pkg::WB_ADDR_RD,
    parameter logic [1:0] WB_ADDR_RT   = pipe_stage_chain_pkg::WB_ADDR_RT,
    parameter logic [1:0] WB_ADDR_LINK = pipe_stage_chain_pkg::WB_ADDR_LINK
) (
    input logic               clk,
    input logic               rst_n,
    pipe_stage_chain_if.slave bus
);

    import pipe_stage_chain_pkg::ctl_t;
    import pipe_stage_chain_pkg::ctl_gate;
    import pipe_stage_chain_pkg::CtlWidth;
    import pipe_stage_chain_pkg::LinkReg;

    logic        if_valid_q;
    logic        id_valid, exe_valid, mem_valid, wb_valid;
    logic        id_data_unused;
    logic [4:0]  id_addr;
    ctl_t        id_ctl, exe_ctl, mem_ctl, wb_ctl;
    ctl_t        exe_out, mem_out, wb_out;
    logic [31:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
        end else if (bus.if_rst) begin
            if_valid_q <= 1'b0;
        end else if (bus.if_en) begin
            if_valid_q <= 1'b1;
        end
    end

    always_comb begin
        id_addr = 5'd0;
        if (bus.wb_addr_src == WB_ADDR_RD) begin
            id_addr = bus.inst[15:11];
        end else if (bus.wb_addr_src == WB_ADDR_RT) begin
            id_addr = bus.inst[20:16];
        end else if (bus.wb_addr_src == WB_ADDR_LINK) begin
            id_addr = LinkReg;
        end
    end

    always_comb begin
        id_ctl.regw_addr   = id_addr;
        id_ctl.is_branch   = (bus.pc_src != PC_NEXT);
        id_ctl.wb_wen      = bus.wb_wen;
        id_ctl.wb_data_src = bus.wb_data_src;
        id_ctl.mem_ren     = bus.mem_ren;
        id_ctl.mem_wen     = bus.mem_wen;
    end

    // ID carries only its valid bit; the decode fields are live ID inputs.
    stage_reg #(.Width(1)) u_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.id_rst),
        .en_i    (bus.id_en),
        .valid_i (if_valid_q),
        .data_i  (1'b0),
        .valid_o (id_valid),
        .data_o  (id_data_unused)
    );

    stage_reg #(.Width(CtlWidth)) u_exe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.exe_rst),
        .en_i    (bus.exe_en),
        .valid_i (id_valid),
        .data_i  (ctl_gate(id_ctl, id_valid)),
        .valid_o (exe_valid),
        .data_o  (exe_ctl)
    );

    stage_reg #(.Width(CtlWidth)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.mem_rst),
        .en_i    (bus.mem_en),
        .valid_i (exe_valid),
        .data_i  (exe_ctl),
        .valid_o (mem_valid),
        .data_o  (mem_ctl)
    );

    stage_reg #(.Width(CtlWidth)) u_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.wb_rst),
        .en_i    (bus.wb_en),
        .valid_i (mem_valid),
        .data_i  (mem_ctl),
        .valid_o (wb_valid),
        .data_o  (wb_ctl)
    );

    always_comb begin
        retired_d = retired_q;
        illegal_d = illegal_q;
        if (wb_valid && bus.wb_en && !bus.wb_rst) begin
            retired_d = retired_q + 32'd1;
        end
        if (bus.exe_en && !bus.exe_rst && id_valid && bus.unrecognized) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign exe_out = ctl_gate(exe_ctl, exe_valid);
    assign mem_out = ctl_gate(mem_ctl, mem_valid);
    assign wb_out  = ctl_gate(wb_ctl, wb_valid);

    assign bus.if_valid        = if_valid_q;
    assign bus.id_valid        = id_valid;
    assign bus.exe_valid       = exe_valid;
    assign bus.mem_valid       = mem_valid;
    assign bus.wb_valid        = wb_valid;
    assign bus.is_branch_exe   = exe_out.is_branch;
    assign bus.wb_wen_exe      = exe_out.wb_wen;
    assign bus.wb_data_src_exe = exe_out.wb_data_src;
    assign bus.regw_addr_exe   = exe_out.regw_addr;
    assign bus.is_branch_mem   = mem_out.is_branch;
    assign bus.wb_wen_mem      = mem_out.wb_wen;
    assign bus.wb_data_src_mem = mem_out.wb_data_src;
    assign bus.regw_addr_mem   = mem_out.regw_addr;
    assign bus.mem_ren_mem     = mem_out.mem_ren;
    assign bus.mem_wen_mem     = mem_out.mem_wen;
    assign bus.regw_addr_wb    = wb_out.regw_addr;
    assign bus.wb_wen_wb       = wb_out.wb_wen;
    assign bus.wb_data_src_wb  = wb_out.wb_data_src;
    assign bus.retired         = retired_q;
    assign bus.illegal_seen    = illegal_q;

    logic ctl_unused;
    assign ctl_unused = ^{exe_out.mem_ren, exe_out.mem_wen, wb_out.is_branch,
                          wb_out.mem_ren, wb_out.mem_wen};

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain with hand-computed expectations.
module tb_pipe_stage_chain;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_stage_chain_if bus ();

    pipe_stage_chain dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        bus.inst         = 32'd0;
        bus.pc_src       = 3'd0;
        bus.wb_addr_src  = 2'd0;
        bus.wb_data_src  = 1'b0;
        bus.wb_wen       = 1'b0;
        bus.mem_ren      = 1'b0;
        bus.mem_wen      = 1'b0;
        bus.unrecognized = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst} = 5'b0;
        {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en} = 5'b11111;
        set_nop();
        #3;
        chk("rst_valids", 32'({bus.if_valid, bus.id_valid, bus.exe_valid, bus.mem_valid,
                               bus.wb_valid}), 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_illegal", 32'(bus.illegal_seen), 32'd0);
        bus.unrecognized = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("edge1_if_valid", 32'(bus.if_valid), 32'd1);
        chk("edge1_id_valid", 32'(bus.id_valid), 32'd0);
        chk("illegal_no_id_valid", 32'(bus.illegal_seen), 32'd0);
        bus.unrecognized = 1'b0;
        tick();
        tick();
        tick();
        chk("edge4_mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("edge4_wb_valid", 32'(bus.wb_valid), 32'd0);
        tick();
        chk("edge5_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("edge5_retired", bus.retired, 32'd0);
    endtask

    task automatic test_add();
        bus.inst        = 32'h0022_2820; // add $5, $1, $2
        bus.wb_addr_src = 2'd0;
        bus.wb_wen      = 1'b1;
        tick();
        chk("add_addr_exe", 32'(bus.regw_addr_exe), 32'd5);
        chk("add_wen_exe", 32'(bus.wb_wen_exe), 32'd1);
        set_nop();
        tick();
        chk("add_addr_mem", 32'(bus.regw_addr_mem), 32'd5);
        chk("add_wen_mem", 32'(bus.wb_wen_mem), 32'd1);
        chk("nop_wen_exe", 32'(bus.wb_wen_exe), 32'd0);
        tick();
        chk("add_addr_wb", 32'(bus.regw_addr_wb), 32'd5);
        chk("add_wen_wb", 32'(bus.wb_wen_wb), 32'd1);
        bus.inst        = 32'h8C29_0000; // rt = 9
        bus.wb_addr_src = 2'd1;
        tick();
        chk("rt_addr_exe", 32'(bus.regw_addr_exe), 32'd9);
        bus.inst        = 32'h0022_2820;
        bus.wb_addr_src = 2'd3;
        tick();
        chk("bad_sel_addr_exe", 32'(bus.regw_addr_exe), 32'd0);
        set_nop();
    endtask

    task automatic test_jal();
        bus.inst        = 32'h0C00_0010;
        bus.pc_src      = 3'd2;
        bus.wb_addr_src = 2'd2;
        bus.wb_wen      = 1'b1;
        tick();
        chk("jal_branch_exe", 32'(bus.is_branch_exe), 32'd1);
        chk("jal_addr_exe", 32'(bus.regw_addr_exe), 32'd31);
        set_nop();
        bus.id_rst = 1'b1;
        tick();
        chk("idrst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("jal_branch_mem", 32'(bus.is_branch_mem), 32'd1);
        chk("nop_branch_exe", 32'(bus.is_branch_exe), 32'd0);
        bus.id_rst = 1'b0;
        tick();
        chk("refill_id_valid", 32'(bus.id_valid), 32'd1);
        chk("bubble_exe_valid", 32'(bus.exe_valid), 32'd0);
    endtask

    task automatic test_stall();
        bus.inst   = 32'h0022_3820; // add $7, $1, $2
        bus.wb_wen = 1'b1;
        tick();
        bus.inst        = 32'h8C28_0004; // lw $8, 4($1)
        bus.wb_addr_src = 2'd1;
        bus.wb_data_src = 1'b1;
        bus.mem_ren     = 1'b1;
        bus.wb_wen      = 1'b1;
        bus.if_en       = 1'b0;
        bus.id_en       = 1'b0;
        bus.exe_rst     = 1'b1;
        tick();
        chk("stall_exe_valid", 32'(bus.exe_valid), 32'd0);
        chk("stall_wen_exe", 32'(bus.wb_wen_exe), 32'd0);
        chk("stall_id_valid", 32'(bus.id_valid), 32'd1);
        chk("stall_addr_mem", 32'(bus.regw_addr_mem), 32'd7);
        chk("stall_wen_mem", 32'(bus.wb_wen_mem), 32'd1);
        bus.if_en   = 1'b1;
        bus.id_en   = 1'b1;
        bus.exe_rst = 1'b0;
        tick();
        chk("lw_addr_exe", 32'(bus.regw_addr_exe), 32'd8);
        chk("lw_dsrc_exe", 32'(bus.wb_data_src_exe), 32'd1);
        chk("bubble_mem_valid", 32'(bus.mem_valid), 32'd0);
        set_nop();
        tick();
        chk("lw_ren_mem", 32'(bus.mem_ren_mem), 32'd1);
        chk("lw_dsrc_mem", 32'(bus.wb_data_src_mem), 32'd1);
        chk("lw_wen_mem_strobe", 32'(bus.mem_wen_mem), 32'd0);
    endtask

    task automatic test_retire();
        tick();
        tick();
        tick();
        chk("pre_wb_valid", 32'(bus.wb_valid), 32'd1);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        chk("forced_retired", bus.retired, 32'hFFFF_FFFF);
        tick();
        chk("retired_wrap", bus.retired, 32'd0);
        bus.wb_en = 1'b0;
        tick();
        chk("retired_hold_en0", bus.retired, 32'd0);
        bus.wb_en = 1'b1;
        tick();
        chk("retired_inc", bus.retired, 32'd1);
        bus.wb_rst = 1'b1;
        tick();
        chk("retired_wbrst", bus.retired, 32'd1);
        chk("wbrst_wb_valid", 32'(bus.wb_valid), 32'd0);
        bus.wb_rst = 1'b0;
        tick();
        chk("retired_after_bubble", bus.retired, 32'd1);
        tick();
        chk("retired_resume", bus.retired, 32'd2);
    endtask

    task automatic test_illegal();
        bus.unrecognized = 1'b1;
        tick();
        chk("illegal_set", 32'(bus.illegal_seen), 32'd1);
        bus.unrecognized = 1'b0;
        tick();
        tick();
        chk("illegal_sticky", 32'(bus.illegal_seen), 32'd1);
        bus.inst   = 32'h0022_2820;
        bus.wb_wen = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valids", 32'({bus.if_valid, bus.id_valid, bus.exe_valid, bus.mem_valid,
                                  bus.wb_valid}), 32'd0);
        chk("midrst_ctl", 32'({bus.regw_addr_exe, bus.regw_addr_mem, bus.regw_addr_wb,
                               bus.wb_wen_exe, bus.wb_wen_mem, bus.wb_wen_wb}), 32'd0);
        chk("midrst_retired", bus.retired, 32'd0);
        chk("midrst_illegal", 32'(bus.illegal_seen), 32'd0);
        set_nop();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_jal();
        test_stall();
        test_retire();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter PC_NEXT, default 3'd0, meaning pc_src code for "no jump/branch".
REQ-002 SHALL have parameters WB_ADDR_RD/RT/LINK, defaults 2'd0/2'd1/2'd2, meaning the write-address select codes.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports {if,id,exe,mem,wb}_rst, input, 1 each, meaning synchronous stage clear from the pipeline controller.
REQ-006 SHALL have ports {if,id,exe,mem,wb}_en, input, 1 each, meaning stage load enable from the pipeline controller.
REQ-007 SHALL have port inst, input, 32, meaning the instruction currently in ID.
REQ-008 SHALL have ports pc_src (3), wb_addr_src (2), wb_data_src, wb_wen, mem_ren, mem_wen and unrecognized (1 each), all inputs, meaning the ID-stage decode outputs.
REQ-009 SHALL have ports {if,id,exe,mem,wb}_valid, output, 1 each, meaning the stage holds a real instruction.
REQ-010 SHALL have ports is_branch_exe, wb_wen_exe and wb_data_src_exe (1 each) and regw_addr_exe (5), all outputs, meaning the EXE-stage feedback.
REQ-011 SHALL have ports is_branch_mem, wb_wen_mem and wb_data_src_mem (1 each) and regw_addr_mem (5), all outputs, meaning the MEM-stage feedback.
REQ-012 SHALL have ports mem_ren_mem and mem_wen_mem, output, 1 each, meaning the data-memory strobes for MEM.
REQ-013 SHALL have ports regw_addr_wb (5), wb_wen_wb (1) and wb_data_src_wb (1), all outputs, meaning the register-file write controls for WB.
REQ-014 SHALL have port retired, output, 32, meaning the count of instructions completed in WB.
REQ-015 SHALL have port illegal_seen, output, 1, meaning a sticky flag: an unrecognized instruction was issued.

Function
REQ-016 SHALL give each stage register this priority: rst_n low, then <stage>_rst (clear), then <stage>_en (load), else hold.
REQ-017 SHALL set if_valid to 1 on a load and to 0 on a clear.
REQ-018 SHALL load id_valid from if_valid, exe_valid from id_valid, mem_valid from exe_valid and wb_valid from mem_valid.
REQ-019 SHALL compute the ID write address combinationally: RD gives inst[15:11], RT gives inst[20:16], LINK gives 5'd31, and any other code gives 0.
REQ-020 SHALL compute is_branch in ID as (pc_src != PC_NEXT).
REQ-021 SHALL capture the ID write address, is_branch, wb_wen, wb_data_src, mem_ren and mem_wen into the EXE register on an EXE load, each ANDed with id_valid.
REQ-022 SHALL copy the EXE register fields into the MEM register on a MEM load, and the MEM register fields into the WB register on a WB load.
REQ-023 SHALL zero every control field on a stage clear, so that a cleared stage is a bubble.
REQ-024 SHALL drive every *_exe, *_mem and *_wb output from its register with no combinational path from ID inputs, giving 1-cycle latency per stage.
REQ-025 SHALL force wb_wen_*, is_branch_*, mem_ren_mem and mem_wen_mem to 0 whenever the owning stage's valid is 0.
REQ-026 SHALL increment retired at an edge where wb_valid=1 and wb_en=1 and wb_rst=0, wrapping modulo 2^32 (FFFFFFFF goes to 0).
REQ-027 SHALL set illegal_seen at an EXE load with id_valid=1 and unrecognized=1, and clear it only by rst_n.
REQ-028 SHALL, under a stall (if_en=id_en=0, exe_rst=1), hold the IF/ID state and place a bubble in EXE, while MEM and WB still advance.
REQ-029 SHALL, when a stage has both rst=1 and en=1 in the same cycle, apply the clear only.

Reset
REQ-030 SHALL, while rst_n is low, immediately force every valid, every control field, retired and illegal_seen to 0, independent of clk.
REQ-031 SHALL, after rst_n deasserts, take 1 cycle to set if_valid and 4 further loads to set wb_valid; mid-operation assertion discards all in-flight instructions.

Structure
REQ-032 SHALL take the PC_*, WB_ADDR_* and WB_DATA_* encodings from the shared MIPS definitions include, and SHALL NOT redefine them locally.
REQ-033 SHALL implement each stage as one instance of a sub-module stage_reg (parameterised width, with valid, clear/enable/hold behaviour), instantiated four times.

Verification
REQ-034 SHALL verify: rst_n low, then released with all en=1 -> if_valid=1 after edge 1 and wb_valid=1 after edge 5.
REQ-035 SHALL verify: ADD with rd=5 and wb_wen=1 (ID) -> regw_addr_exe=5 and wb_wen_exe=1 after 1 edge, regw_addr_mem=5 after 2 edges, regw_addr_wb=5 after 3 edges.
REQ-036 SHALL verify: JAL with pc_src!=0 and wb_addr_src=LINK -> is_branch_exe=1 and regw_addr_exe=31; next edge with id_rst=1 -> id_valid=0.
REQ-037 SHALL verify: LW in ID with exe_rst=1 and id_en=0 for 1 cycle -> exe_valid=0 and wb_wen_exe=0, the LW is retained in ID, and MEM receives the previous EXE contents.
REQ-038 SHALL verify: retired preset to 32'hFFFFFFFF by 2^32-1 retirements via force, then one retirement -> retired=0; with wb_en=0 -> no increment.
REQ-039 SHALL verify: unrecognized=1 with id_valid=1 and an EXE load -> illegal_seen=1 and sticky; rst_n pulsed mid-stream -> all outputs 0 at once.
